ysyx_23060077_lsu: RTL and testbench
====================================

Name: ysyx_23060077_lsu

Overview:
Load/store stage directly downstream of the execute stage.
- Takes the registered execute result (address, or the ALU result for non-memory instructions) plus the store data and funct3.
- Runs one AXI4-Lite-style memory transaction for loads and stores; non-memory instructions pass straight through.
- Outputs a registered result, a finished flag for the writeback handshake, and a stall flag.

Parameters:
- DATA_WIDTH, 32, data and address width; only 32 is supported.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset; one clock domain
- ex_to_ls  in  1  one-cycle pulse; operands below are valid and held until lsu_finished
- ex_result  in  32  address (mem op) or pass-through value
- store_data  in  32  rs2 value for stores
- funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- mem_ren  in  1  load
- mem_wen  in  1  store; mem_ren and mem_wen are never both 1
- ls_to_wb  in  1  writeback has consumed the result; clears lsu_finished
- araddr  out  32;  arvalid  out  1;  arready  in  1
- rdata  in  32;  rresp  in  2;  rvalid  in  1;  rready  out  1
- awaddr  out  32;  awvalid  out  1;  awready  in  1
- wdata  out  32;  wstrb  out  4;  wvalid  out  1;  wready  in  1
- bresp  in  2;  bvalid  in  1;  bready  out  1
- lsu_result  out  32  registered load data or pass-through value
- lsu_finished  out  1  result valid; held until ls_to_wb
- lsu_stall  out  1  a memory transaction is in flight
- lsu_bus_err  out  1  registered; set on a nonzero rresp or bresp for the current op

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE. All valid/ready outputs are 0. lsu_result, lsu_finished, lsu_stall and lsu_bus_err are 0. Address/data outputs are 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE, on ex_to_ls:
  - mem_ren goes to RD_ADDR. araddr = {ex_result[31:2],2'b00} and arvalid=1 in the next cycle.
  - mem_wen goes to WR_REQ. awvalid and wvalid are both asserted the next cycle.
  - Neither set: lsu_result <= ex_result and the block goes to DONE. lsu_finished is 1 one cycle after ex_to_ls.
- RD_ADDR: hold arvalid until arready. On the handshake, drop arvalid and go to RD_DATA with rready=1.
- RD_DATA: on rvalid, capture data and go to DONE.
  - Lane select is addr[1:0] (byte) or addr[1] (half).
  - Sign-extend for funct3 000/001, zero-extend for 100/101.
  - funct3 010 takes the whole word.
- WR_REQ: the AW and W handshakes are independent.
  - Each valid drops after its own handshake. Both handshakes may occur in the same cycle.
  - Leave for WR_RESP (bready=1) only after both have completed.
  - wstrb: sb gives 4'b0001<<addr[1:0]; sh gives 4'b0011<<{addr[1],1'b0}; sw gives 4'b1111.
  - wdata: store_data replicated into every lane.
- WR_RESP: on bvalid go to DONE. lsu_result is 0 for stores.
- DONE: lsu_finished=1 and lsu_stall=0. Stay in DONE until ls_to_wb, then return to IDLE with lsu_finished cleared.
- Back-to-back: an ex_to_ls arriving in the same cycle as ls_to_wb is accepted; the DONE to IDLE transition and the new dispatch happen together.
- An ex_to_ls arriving while not in IDLE/DONE is a protocol violation; the bench asserts on it.
- lsu_stall=1 in RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
- Nonzero rresp or bresp: the transaction still completes, and lsu_bus_err=1 until the next ex_to_ls clears it.
- Reset mid-transaction: all state drops immediately with no drain. The bus slave is reset in the same cycle.

Optional Feature:
- Macro: YSYX_23060077_LSU_MISALIGN_CHECK_EN.
- Defined: adds output lsu_misalign (1 bit, reset 0).
  - Misaligned cases: a halfword with addr[0]=1, or a word with addr[1:0]!=0.
  - Such an access goes IDLE to DONE with no bus transaction, lsu_result=0 and lsu_misalign=1.
  - lsu_misalign is cleared by the next ex_to_ls.
- Undefined: no such port. The low address bits are used only for lane selection; a misaligned word access is issued as aligned.

Decomposition:
- Shared define file holds:
  - State encodings (LSU_IDLE to LSU_DONE).
  - funct3 load/store codes.
  - AXI resp codes (OKAY=2'b00).
- One sub-module: ysyx_23060077_lsu_align, combinational. It generates wstrb/wdata and extracts and extends load data.
- The FSM and bus registers stay in the top module.

Test Plan:
- Pass-through: ex_to_ls with ex_result=0x1234, mem_ren=mem_wen=0 -> lsu_finished=1 next cycle, lsu_result=0x1234, no arvalid/awvalid.
- lb: addr 0x8000_0003, rdata=0x80FF_0000, arready delayed 3 cycles -> araddr=0x8000_0000, lsu_result=0xFFFF_FF80, lsu_stall high until DONE.
- lhu: addr 0x8000_0002, rdata=0xBEEF_1234 -> lsu_result=0x0000_BEEF.
- sb: addr 0x8000_0001, store_data=0xAB, wready before awready -> wstrb=4'b0010, wdata=0xABABABAB. WR_RESP is entered only after both handshakes; finished after bvalid.
- Error response: a load with rresp=2'b10 -> lsu_finished=1, lsu_bus_err=1. The next ex_to_ls clears lsu_bus_err.
- Reset: drive reset low while in RD_DATA -> next cycle rready=0, lsu_finished=0, state IDLE. With MISALIGN_CHECK_EN defined, lw to 0x...2 -> lsu_misalign=1 and no arvalid.

Source files
------------

// File: rtl/ysyx_23060077_lsu_pkg.sv
// Shared constants for the load/store unit: FSM encodings, funct3 codes, AXI response codes.
// Also holds the misalignment predicate used when YSYX_23060077_LSU_MISALIGN_CHECK_EN is defined.
package ysyx_23060077_lsu_pkg;

    localparam logic [2:0] LSU_IDLE    = 3'd0;
    localparam logic [2:0] LSU_RD_ADDR = 3'd1;
    localparam logic [2:0] LSU_RD_DATA = 3'd2;
    localparam logic [2:0] LSU_WR_REQ  = 3'd3;
    localparam logic [2:0] LSU_WR_RESP = 3'd4;
    localparam logic [2:0] LSU_DONE    = 3'd5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) begin
            mis = 1'b1;
        end
        if (funct3 == F3_W && addr_lo != 2'b00) begin
            mis = 1'b1;
        end
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_23060077_lsu_align.sv
// Combinational lane logic: store strobe/data replication and load extraction with extension.
module ysyx_23060077_lsu_align
    import ysyx_23060077_lsu_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'h0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'h0, half_sel};
            F3_W:    load_data_o = rdata_i;
            default: load_data_o = rdata_i;
        endcase

        // Stores only use sb/sh/sw, so the low two funct3 bits select the size.
        case (funct3_i[1:0])
            2'b00: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = store_data_i;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060077_lsu.sv
// Load/store stage: one AXI4-Lite-style read or write per memory op, pass-through otherwise.
// Optional YSYX_23060077_LSU_MISALIGN_CHECK_EN adds lsu_misalign and skips misaligned accesses.
module ysyx_23060077_lsu
    import ysyx_23060077_lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ex_to_ls,
    input  logic [DATA_WIDTH-1:0] ex_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [2:0]            funct3,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic                  ls_to_wb,
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [DATA_WIDTH-1:0] lsu_result,
    output logic                  lsu_finished,
    output logic                  lsu_stall,
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
    output logic                  lsu_misalign,
`endif
    output logic                  lsu_bus_err
);

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic [DATA_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                  awvalid_q, awvalid_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  wvalid_q, wvalid_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  bus_err_q, bus_err_d;
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
    logic                  misalign_q, misalign_d;
`endif

    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        accept;

    // Operands stay stable until lsu_finished, so lane selection can read them directly.
    ysyx_23060077_lsu_align u_align (
        .addr_lo_i    (ex_result[1:0]),
        .funct3_i     (funct3),
        .store_data_i (store_data),
        .rdata_i      (rdata),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .load_data_o  (al_load)
    );

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        awaddr_d  = awaddr_q;
        awvalid_d = awvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        result_d  = result_q;
        bus_err_d = bus_err_q;
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        accept = ex_to_ls && (state_q == LSU_IDLE || (state_q == LSU_DONE && ls_to_wb));

        case (state_q)
            LSU_IDLE: ;
            LSU_RD_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    state_d   = LSU_RD_DATA;
                end
            end
            LSU_RD_DATA: begin
                if (rvalid) begin
                    result_d  = al_load;
                    bus_err_d = (rresp != RESP_OKAY);
                    state_d   = LSU_DONE;
                end
            end
            LSU_WR_REQ: begin
                aw_done_d = aw_done_q | (awvalid_q & awready);
                w_done_d  = w_done_q | (wvalid_q & wready);
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = LSU_WR_RESP;
                end
            end
            LSU_WR_RESP: begin
                if (bvalid) begin
                    result_d  = '0;
                    bus_err_d = (bresp != RESP_OKAY);
                    state_d   = LSU_DONE;
                end
            end
            LSU_DONE: begin
                if (ls_to_wb) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase

        // Dispatch overrides the DONE->IDLE step so back-to-back ops lose no cycle.
        if (accept) begin
            bus_err_d = 1'b0;
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
            misalign_d = 1'b0;
            if ((mem_ren || mem_wen) && is_misaligned(funct3, ex_result[1:0])) begin
                result_d   = '0;
                misalign_d = 1'b1;
                state_d    = LSU_DONE;
            end else
`endif
            if (mem_ren) begin
                araddr_d  = {ex_result[DATA_WIDTH-1:2], 2'b00};
                arvalid_d = 1'b1;
                state_d   = LSU_RD_ADDR;
            end else if (mem_wen) begin
                awaddr_d  = {ex_result[DATA_WIDTH-1:2], 2'b00};
                awvalid_d = 1'b1;
                wdata_d   = al_wdata;
                wstrb_d   = al_wstrb;
                wvalid_d  = 1'b1;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = LSU_WR_REQ;
            end else begin
                result_d = ex_result;
                state_d  = LSU_DONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= LSU_IDLE;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awvalid_q <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            result_q  <= '0;
            bus_err_q <= 1'b0;
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            awaddr_q  <= awaddr_d;
            awvalid_q <= awvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            result_q  <= result_d;
            bus_err_q <= bus_err_d;
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign araddr       = araddr_q;
    assign arvalid      = arvalid_q;
    assign rready       = (state_q == LSU_RD_DATA);
    assign awaddr       = awaddr_q;
    assign awvalid      = awvalid_q;
    assign wdata        = wdata_q;
    assign wstrb        = wstrb_q;
    assign wvalid       = wvalid_q;
    assign bready       = (state_q == LSU_WR_RESP);
    assign lsu_result   = result_q;
    assign lsu_finished = (state_q == LSU_DONE);
    assign lsu_stall    = (state_q == LSU_RD_ADDR) || (state_q == LSU_RD_DATA) ||
                          (state_q == LSU_WR_REQ) || (state_q == LSU_WR_RESP);
    assign lsu_bus_err  = bus_err_q;
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
    assign lsu_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_ysyx_23060077_lsu.sv
// Scoreboard bench for ysyx_23060077_lsu: drives ops, plays the AXI slave, compares results.
module tb_ysyx_23060077_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_to_ls;
    logic [31:0] ex_result;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic        mem_ren;
    logic        mem_wen;
    logic        ls_to_wb;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] lsu_result;
    logic        lsu_finished;
    logic        lsu_stall;
    logic        lsu_bus_err;
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
    logic        lsu_misalign;
`endif

    always #5 clock = ~clock;

    ysyx_23060077_lsu #(.DATA_WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .ex_to_ls     (ex_to_ls),
        .ex_result    (ex_result),
        .store_data   (store_data),
        .funct3       (funct3),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .ls_to_wb     (ls_to_wb),
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready),
        .awaddr       (awaddr),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready),
        .lsu_result   (lsu_result),
        .lsu_finished (lsu_finished),
        .lsu_stall    (lsu_stall),
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
        .lsu_misalign (lsu_misalign),
`endif
        .lsu_bus_err  (lsu_bus_err)
    );

    typedef struct packed {
        logic [31:0] result;
        logic        bus_err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // All driving and sampling happens on the falling edge; the DUT acts on the rising edge.
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic dispatch(input logic [31:0] res, input logic [31:0] sd, input logic [2:0] f3,
                            input logic ren, input logic wen,
                            input logic [31:0] exp_res, input logic exp_err);
        exp_t e;
        check_eq("stall_at_dispatch", 32'(lsu_stall), 32'd0);
        ex_result  = res;
        store_data = sd;
        funct3     = f3;
        mem_ren    = ren;
        mem_wen    = wen;
        ex_to_ls   = 1'b1;
        e.result   = exp_res;
        e.bus_err  = exp_err;
        sb_q.push_back(e);
        tick();
        ex_to_ls = 1'b0;
    endtask

    task automatic expect_result(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!lsu_finished && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_finished"}, 32'(lsu_finished), 32'd1);
        check_eq({tag, "_stall_done"}, 32'(lsu_stall), 32'd0);
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_nonempty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_result"}, lsu_result, e.result);
            check_eq({tag, "_bus_err"}, 32'(lsu_bus_err), 32'(e.bus_err));
        end
    endtask

    task automatic release_wb();
        ls_to_wb = 1'b1;
        tick();
        ls_to_wb = 1'b0;
        check_eq("finished_cleared", 32'(lsu_finished), 32'd0);
    endtask

    task automatic serve_read(input int ar_delay, input logic [31:0] data, input logic [1:0] resp,
                              input logic [31:0] exp_addr);
        check_eq("arvalid", 32'(arvalid), 32'd1);
        check_eq("araddr", araddr, exp_addr);
        check_eq("awvalid_on_read", 32'(awvalid), 32'd0);
        for (int i = 0; i < ar_delay; i++) begin
            tick();
        end
        check_eq("arvalid_held", 32'(arvalid), 32'd1);
        check_eq("stall_rd_addr", 32'(lsu_stall), 32'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check_eq("arvalid_drop", 32'(arvalid), 32'd0);
        check_eq("rready", 32'(rready), 32'd1);
        check_eq("stall_rd_data", 32'(lsu_stall), 32'd1);
        rdata  = data;
        rresp  = resp;
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        rdata  = '0;
        rresp  = 2'b00;
    endtask

    task automatic serve_write(input int aw_d, input int w_d, input logic [1:0] resp,
                               input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                               input logic [31:0] exp_data);
        int last;
        last = (aw_d > w_d) ? aw_d : w_d;
        check_eq("awvalid", 32'(awvalid), 32'd1);
        check_eq("wvalid", 32'(wvalid), 32'd1);
        check_eq("arvalid_on_write", 32'(arvalid), 32'd0);
        check_eq("awaddr_hi", {2'b00, awaddr[31:2]}, {2'b00, exp_addr[31:2]});
        check_eq("wstrb", 32'(wstrb), 32'(exp_strb));
        check_eq("wdata", wdata, exp_data);
        for (int c = 0; c <= last; c++) begin
            awready = (c == aw_d);
            wready  = (c == w_d);
            tick();
            check_eq("awvalid_track", 32'(awvalid), 32'(c < aw_d));
            check_eq("wvalid_track", 32'(wvalid), 32'(c < w_d));
            check_eq("bready_after_both", 32'(bready), 32'(c == last));
        end
        awready = 1'b0;
        wready  = 1'b0;
        check_eq("stall_wr_resp", 32'(lsu_stall), 32'd1);
        bresp  = resp;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        bresp  = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        ex_to_ls   = 1'b0;
        ex_result  = '0;
        store_data = '0;
        funct3     = 3'b000;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        ls_to_wb   = 1'b0;
        arready    = 1'b0;
        rdata      = '0;
        rresp      = 2'b00;
        rvalid     = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        bresp      = 2'b00;
        bvalid     = 1'b0;
        repeat (2) tick();

        check_eq("rst_result", lsu_result, 32'd0);
        check_eq("rst_finished", 32'(lsu_finished), 32'd0);
        check_eq("rst_stall", 32'(lsu_stall), 32'd0);
        check_eq("rst_bus_err", 32'(lsu_bus_err), 32'd0);
        check_eq("rst_valids", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
        check_eq("rst_readies", {30'd0, rready, bready}, 32'd0);
        check_eq("rst_araddr", araddr, 32'd0);
        check_eq("rst_wstrb", 32'(wstrb), 32'd0);
        reset = 1'b1;
        tick();

        // Pass-through: finished one cycle after dispatch, no bus activity.
        dispatch(32'h0000_1234, 32'h0, 3'b010, 1'b0, 1'b0, 32'h0000_1234, 1'b0);
        check_eq("pass_finished_next", 32'(lsu_finished), 32'd1);
        check_eq("pass_no_bus", {30'd0, arvalid, awvalid}, 32'd0);
        expect_result("pass");
        release_wb();

        dispatch(32'h8000_0003, 32'h0, 3'b000, 1'b1, 1'b0, 32'hFFFF_FF80, 1'b0);
        serve_read(3, 32'h80FF_0000, 2'b00, 32'h8000_0000);
        expect_result("lb");
        release_wb();

        dispatch(32'h8000_0002, 32'h0, 3'b101, 1'b1, 1'b0, 32'h0000_BEEF, 1'b0);
        serve_read(0, 32'hBEEF_1234, 2'b00, 32'h8000_0000);
        expect_result("lhu");
        release_wb();

        dispatch(32'h8000_0010, 32'h0, 3'b001, 1'b1, 1'b0, 32'hFFFF_8001, 1'b0);
        serve_read(0, 32'h1234_8001, 2'b00, 32'h8000_0010);
        expect_result("lh");
        release_wb();

        dispatch(32'h8000_0021, 32'h0, 3'b100, 1'b1, 1'b0, 32'h0000_00F2, 1'b0);
        serve_read(1, 32'h0000_F200, 2'b00, 32'h8000_0020);
        expect_result("lbu");
        release_wb();

        dispatch(32'h8000_0004, 32'h0, 3'b010, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        serve_read(2, 32'hDEAD_BEEF, 2'b00, 32'h8000_0004);
        expect_result("lw");
        release_wb();

        // sb with W accepted before AW.
        dispatch(32'h8000_0001, 32'h0000_00AB, 3'b000, 1'b0, 1'b1, 32'h0, 1'b0);
        serve_write(2, 0, 2'b00, 32'h8000_0000, 4'b0010, 32'hABAB_ABAB);
        expect_result("sb");
        release_wb();

        dispatch(32'h8000_0006, 32'h1234_CAFE, 3'b001, 1'b0, 1'b1, 32'h0, 1'b0);
        serve_write(0, 2, 2'b00, 32'h8000_0004, 4'b1100, 32'hCAFE_CAFE);
        expect_result("sh");
        release_wb();

        dispatch(32'h8000_0008, 32'h1122_3344, 3'b010, 1'b0, 1'b1, 32'h0, 1'b0);
        serve_write(1, 1, 2'b00, 32'h8000_0008, 4'b1111, 32'h1122_3344);
        expect_result("sw");
        release_wb();

        // Error response on a load; the next dispatch clears the flag.
        dispatch(32'h8000_0040, 32'h0, 3'b010, 1'b1, 1'b0, 32'h55AA_55AA, 1'b1);
        serve_read(0, 32'h55AA_55AA, 2'b10, 32'h8000_0040);
        expect_result("rd_err");
        release_wb();
        dispatch(32'hCAFE_0001, 32'h0, 3'b010, 1'b0, 1'b0, 32'hCAFE_0001, 1'b0);
        check_eq("bus_err_cleared", 32'(lsu_bus_err), 32'd0);
        expect_result("pass_after_err");
        release_wb();

        dispatch(32'h8000_0050, 32'hFFFF_FFFF, 3'b010, 1'b0, 1'b1, 32'h0, 1'b1);
        serve_write(0, 1, 2'b11, 32'h8000_0050, 4'b1111, 32'hFFFF_FFFF);
        expect_result("wr_err");

        // Back-to-back: release and new dispatch in the same cycle.
        ls_to_wb = 1'b1;
        dispatch(32'h0BAD_F00D, 32'h0, 3'b010, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);
        ls_to_wb = 1'b0;
        check_eq("b2b_finished", 32'(lsu_finished), 32'd1);
        expect_result("b2b");
        release_wb();

        // Reset while waiting for read data.
        dispatch(32'h8000_0060, 32'h0, 3'b010, 1'b1, 1'b0, 32'h0, 1'b0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check_eq("pre_rst_rready", 32'(rready), 32'd1);
        reset = 1'b0;
        tick();
        void'(sb_q.pop_front());
        check_eq("mid_rst_rready", 32'(rready), 32'd0);
        check_eq("mid_rst_finished", 32'(lsu_finished), 32'd0);
        check_eq("mid_rst_stall", 32'(lsu_stall), 32'd0);
        check_eq("mid_rst_araddr", araddr, 32'd0);
        reset = 1'b1;
        tick();

        dispatch(32'h0000_5A5A, 32'h0, 3'b010, 1'b0, 1'b0, 32'h0000_5A5A, 1'b0);
        expect_result("pass_after_rst");
        release_wb();

`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
        dispatch(32'h8000_0002, 32'h0, 3'b010, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("mis_no_arvalid", 32'(arvalid), 32'd0);
        check_eq("mis_flag", 32'(lsu_misalign), 32'd1);
        expect_result("misalign");
        release_wb();
        dispatch(32'h0000_0007, 32'h0, 3'b010, 1'b0, 1'b0, 32'h0000_0007, 1'b0);
        check_eq("mis_cleared", 32'(lsu_misalign), 32'd0);
        expect_result("pass_after_mis");
        release_wb();
`endif

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
